// File: rtl/rv_exec_datapath_if.sv
// Signal bundle between the RV32I execute-stage datapath and its surroundings.
// The slave modport is the datapath side; the master modport is the driving side.
interface rv_exec_datapath_if #(
    parameter int SIZE = 32
);
    logic [6:0]      OPCODE;
    logic [2:0]      FUNCT3;
    logic            BIT30;
    logic [4:0]      RS1;
    logic [4:0]      RS2;
    logic [4:0]      RD;
    logic            REG_WRITE;
    logic [SIZE-1:0] WRITE_DATA;
    logic [SIZE-1:0] IMM;
    logic [SIZE-1:0] PC;
    logic [1:0]      A_SEL;
    logic            ALU_SRC;
    logic [SIZE-1:0] DATA1;
    logic [SIZE-1:0] DATA2;
    logic [3:0]      ALU_OP;
    logic [SIZE-1:0] ALU_RESULT;
    logic            ZERO;

    modport slave (
        input  OPCODE, FUNCT3, BIT30, RS1, RS2, RD, REG_WRITE, WRITE_DATA,
               IMM, PC, A_SEL, ALU_SRC,
        output DATA1, DATA2, ALU_OP, ALU_RESULT, ZERO
    );

    modport master (
        output OPCODE, FUNCT3, BIT30, RS1, RS2, RD, REG_WRITE, WRITE_DATA,
               IMM, PC, A_SEL, ALU_SRC,
        input  DATA1, DATA2, ALU_OP, ALU_RESULT, ZERO
    );
endinterface

// File: rtl/rv_exec_datapath.sv
// RV32I execute stage: register bank, ALU-control decode, operand muxes and ALU.
// Define RF_WRITE_BYPASS_EN to make reads of the register being written return WRITE_DATA.
module rv_exec_datapath #(
    parameter int SIZE  = 32,
    parameter int NREGS = 32
) (
    input  logic              CLK,
    input  logic              RESET_N,
    rv_exec_datapath_if.slave bus
);
    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_BR = 7'b1100011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    logic [SIZE-1:0] regs_q [NREGS];
    logic [SIZE-1:0] data1;
    logic [SIZE-1:0] data2;
    alu_op_e         alu_op;
    logic [SIZE-1:0] op_a;
    logic [SIZE-1:0] op_b;
    logic [SIZE-1:0] result;
    logic [4:0]      shamt;
    logic            wr_en;

    assign wr_en = bus.REG_WRITE && (bus.RD != 5'd0);

    // x0 is never written, so its storage stays at reset value.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[bus.RD] <= bus.WRITE_DATA;
        end
    end

    always_comb begin
        data1 = regs_q[bus.RS1];
        data2 = regs_q[bus.RS2];
`ifdef RF_WRITE_BYPASS_EN
        if (wr_en && (bus.RS1 == bus.RD)) data1 = bus.WRITE_DATA;
        if (wr_en && (bus.RS2 == bus.RD)) data2 = bus.WRITE_DATA;
`endif
        if (!RESET_N || (bus.RS1 == 5'd0)) data1 = '0;
        if (!RESET_N || (bus.RS2 == 5'd0)) data2 = '0;
    end

    // I-arith shares the R-type funct3 map; only SUB needs the R-type opcode.
    always_comb begin
        alu_op = ALU_ADD;
        if ((bus.OPCODE == OPC_R) || (bus.OPCODE == OPC_I)) begin
            case (bus.FUNCT3)
                3'b000:  alu_op = ((bus.OPCODE == OPC_R) && bus.BIT30) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op = ALU_SLL;
                3'b010:  alu_op = ALU_SLT;
                3'b011:  alu_op = ALU_SLTU;
                3'b100:  alu_op = ALU_XOR;
                3'b101:  alu_op = bus.BIT30 ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
        end else if (bus.OPCODE == OPC_BR) begin
            alu_op = ALU_SUB;
        end
    end

    always_comb begin
        case (bus.A_SEL)
            2'd0:    op_a = bus.PC;
            2'd1:    op_a = '0;
            default: op_a = data1;
        endcase
        op_b  = bus.ALU_SRC ? bus.IMM : data2;
        shamt = op_b[4:0];
    end

    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:  result = op_a + op_b;
            ALU_SUB:  result = op_a - op_b;
            ALU_SLL:  result = op_a << shamt;
            ALU_SLT:  result = {{(SIZE-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_SLTU: result = {{(SIZE-1){1'b0}}, (op_a < op_b)};
            ALU_XOR:  result = op_a ^ op_b;
            ALU_SRL:  result = op_a >> shamt;
            ALU_SRA:  result = $unsigned($signed(op_a) >>> shamt);
            ALU_OR:   result = op_a | op_b;
            ALU_AND:  result = op_a & op_b;
            default:  result = '0;
        endcase
    end

    assign bus.DATA1      = data1;
    assign bus.DATA2      = data2;
    assign bus.ALU_OP     = alu_op;
    assign bus.ALU_RESULT = result;
    assign bus.ZERO       = (result == '0);
endmodule

// File: tb/tb_rv_exec_datapath.sv
// Self-checking bench for rv_exec_datapath: directed vector table, hand sequences
// for register-bank corner cases, and randomized ops against a reference model.
module tb_rv_exec_datapath;
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_BR  = 7'b1100011;
    localparam logic [6:0] OPC_LUI = 7'b0110111;
    localparam logic [6:0] OPC_AUI = 7'b0010111;

    logic CLK;
    logic RESET_N;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] model_regs [32];

    rv_exec_datapath_if #(.SIZE(32)) bus_if ();

    rv_exec_datapath #(.SIZE(32), .NREGS(32)) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus_if.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        bit30;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [1:0]  a_sel;
        logic        alu_src;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [3:0]  exp_op;
        logic [31:0] exp_res;
        logic        exp_zero;
    } vec_t;

    vec_t vec_q[$];

    function automatic vec_t mk(logic [6:0] opc, logic [2:0] f3, logic b30,
                                logic [4:0] r1, logic [4:0] r2, logic [1:0] asel,
                                logic src, logic [31:0] imm, logic [31:0] pc,
                                logic [3:0] eop, logic [31:0] eres);
        vec_t v;
        v.opcode = opc; v.funct3 = f3; v.bit30 = b30; v.rs1 = r1; v.rs2 = r2;
        v.a_sel = asel; v.alu_src = src; v.imm = imm; v.pc = pc;
        v.exp_op = eop; v.exp_res = eres; v.exp_zero = (eres == 32'd0);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    task automatic write_reg(input logic [4:0] rd, input logic [31:0] val, input logic we);
        @(negedge CLK);
        bus_if.RD = rd;
        bus_if.WRITE_DATA = val;
        bus_if.REG_WRITE = we;
        @(posedge CLK);
        #1;
        bus_if.REG_WRITE = 1'b0;
        if (we && rd != 5'd0) model_regs[rd] = val;
    endtask

    task automatic drive_op(input vec_t v);
        bus_if.OPCODE = v.opcode; bus_if.FUNCT3 = v.funct3; bus_if.BIT30 = v.bit30;
        bus_if.RS1 = v.rs1; bus_if.RS2 = v.rs2; bus_if.A_SEL = v.a_sel;
        bus_if.ALU_SRC = v.alu_src; bus_if.IMM = v.imm; bus_if.PC = v.pc;
        #1;
    endtask

    // Reference: operation chosen from the instruction fields, then evaluated arithmetically.
    function automatic int model_op(logic [6:0] opc, logic [2:0] f3, logic b30);
        if (opc == OPC_R || opc == OPC_I) begin
            case (f3)
                3'd0: return (opc == OPC_R && b30) ? 1 : 0;
                3'd1: return 2;
                3'd2: return 3;
                3'd3: return 4;
                3'd4: return 5;
                3'd5: return b30 ? 7 : 6;
                3'd6: return 8;
                default: return 9;
            endcase
        end
        if (opc == OPC_BR) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] model_alu(int op, logic [31:0] a, logic [31:0] b);
        int sh;
        longint sa, sb;
        sh = int'(b % 32);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            0: return a + b;
            1: return a + (~b + 32'd1);
            2: return a * (32'd1 << sh);
            3: return (sa < sb) ? 32'd1 : 32'd0;
            4: return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
            5: return a ^ b;
            6: return a / (32'd1 << sh);
            7: return (a >> sh) | (a[31] ? ~(32'hFFFFFFFF >> sh) : 32'd0);
            8: return a | b;
            9: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic check_model(input vec_t v, input string tag);
        logic [31:0] a, b, d1, d2, r;
        int op;
        d1 = model_regs[v.rs1];
        d2 = model_regs[v.rs2];
        a  = (v.a_sel == 2'd0) ? v.pc : (v.a_sel == 2'd1) ? 32'd0 : d1;
        b  = v.alu_src ? v.imm : d2;
        op = model_op(v.opcode, v.funct3, v.bit30);
        r  = model_alu(op, a, b);
        drive_op(v);
        check({tag, "_data1"}, bus_if.DATA1, d1);
        check({tag, "_data2"}, bus_if.DATA2, d2);
        check({tag, "_op"}, {28'd0, bus_if.ALU_OP}, op);
        check({tag, "_res"}, bus_if.ALU_RESULT, r);
        check({tag, "_zero"}, {31'd0, bus_if.ZERO}, {31'd0, (r == 32'd0)});
    endtask

    logic [6:0] opc_list [10];
    logic [31:0] old_val;
    vec_t v;

    initial begin
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        opc_list = '{OPC_R, OPC_I, OPC_BR, 7'b0000011, 7'b0100011, OPC_LUI,
                     OPC_AUI, 7'b1101111, 7'b1100111, 7'b1111111};
        RESET_N = 1'b0;
        bus_if.OPCODE = '0; bus_if.FUNCT3 = '0; bus_if.BIT30 = 1'b0;
        bus_if.RS1 = 5'd1; bus_if.RS2 = 5'd2; bus_if.RD = '0;
        bus_if.REG_WRITE = 1'b0; bus_if.WRITE_DATA = '0; bus_if.IMM = '0;
        bus_if.PC = '0; bus_if.A_SEL = 2'd2; bus_if.ALU_SRC = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_data1", bus_if.DATA1, 32'd0);
        check("reset_data2", bus_if.DATA2, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;

        // Asynchronous reset mid-cycle must clear the bank without a clock edge.
        write_reg(5'd5, 32'h1234, 1'b1);
        bus_if.RS1 = 5'd5;
        #1;
        check("x5_written", bus_if.DATA1, 32'h1234);
        @(negedge CLK);
        #2;
        RESET_N = 1'b0;
        #1;
        check("async_reset_x5", bus_if.DATA1, 32'd0);
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
        @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        check("after_reset_x5", bus_if.DATA1, 32'd0);

        write_reg(5'd1, 32'hFFFFFFFF, 1'b1);
        write_reg(5'd2, 32'd5, 1'b1);
        write_reg(5'd3, 32'd7, 1'b1);
        write_reg(5'd4, 32'h80000000, 1'b1);
        write_reg(5'd8, 32'd42, 1'b1);
        write_reg(5'd9, 32'd42, 1'b1);

        vec_q.push_back(mk(OPC_I,   3'b000, 1'b0, 5'd1, 5'd0, 2'd2, 1'b1, 32'd1,        32'd0,     4'd0, 32'd0));
        vec_q.push_back(mk(OPC_R,   3'b000, 1'b1, 5'd2, 5'd3, 2'd2, 1'b0, 32'd0,        32'd0,     4'd1, 32'hFFFFFFFE));
        vec_q.push_back(mk(OPC_R,   3'b000, 1'b0, 5'd2, 5'd3, 2'd3, 1'b0, 32'd0,        32'd0,     4'd0, 32'd12));
        vec_q.push_back(mk(OPC_R,   3'b010, 1'b0, 5'd2, 5'd3, 2'd2, 1'b0, 32'd0,        32'd0,     4'd3, 32'd1));
        vec_q.push_back(mk(OPC_R,   3'b011, 1'b0, 5'd4, 5'd3, 2'd2, 1'b0, 32'd0,        32'd0,     4'd4, 32'd0));
        vec_q.push_back(mk(OPC_R,   3'b010, 1'b0, 5'd4, 5'd3, 2'd2, 1'b0, 32'd0,        32'd0,     4'd3, 32'd1));
        vec_q.push_back(mk(OPC_I,   3'b101, 1'b1, 5'd4, 5'd0, 2'd2, 1'b1, 32'h24,       32'd0,     4'd7, 32'hF8000000));
        vec_q.push_back(mk(OPC_I,   3'b101, 1'b0, 5'd4, 5'd0, 2'd2, 1'b1, 32'h24,       32'd0,     4'd6, 32'h08000000));
        vec_q.push_back(mk(OPC_I,   3'b000, 1'b1, 5'd2, 5'd0, 2'd2, 1'b1, 32'd3,        32'd0,     4'd0, 32'd8));
        vec_q.push_back(mk(OPC_R,   3'b001, 1'b0, 5'd2, 5'd3, 2'd2, 1'b0, 32'd0,        32'd0,     4'd2, 32'h280));
        vec_q.push_back(mk(OPC_R,   3'b100, 1'b0, 5'd2, 5'd3, 2'd2, 1'b0, 32'd0,        32'd0,     4'd5, 32'd2));
        vec_q.push_back(mk(OPC_R,   3'b110, 1'b0, 5'd2, 5'd3, 2'd2, 1'b0, 32'd0,        32'd0,     4'd8, 32'd7));
        vec_q.push_back(mk(OPC_R,   3'b111, 1'b0, 5'd2, 5'd3, 2'd2, 1'b0, 32'd0,        32'd0,     4'd9, 32'd5));
        vec_q.push_back(mk(OPC_BR,  3'b000, 1'b0, 5'd8, 5'd9, 2'd2, 1'b0, 32'd0,        32'd0,     4'd1, 32'd0));
        vec_q.push_back(mk(OPC_LUI, 3'b000, 1'b0, 5'd0, 5'd0, 2'd1, 1'b1, 32'h12345000, 32'd0,     4'd0, 32'h12345000));
        vec_q.push_back(mk(OPC_AUI, 3'b000, 1'b0, 5'd0, 5'd0, 2'd0, 1'b1, 32'h1000,     32'h100,   4'd0, 32'h1100));
        vec_q.push_back(mk(7'b1111111, 3'b101, 1'b1, 5'd2, 5'd3, 2'd2, 1'b0, 32'd0,     32'd0,     4'd0, 32'd12));

        foreach (vec_q[i]) begin
            drive_op(vec_q[i]);
            check($sformatf("vec%0d_op", i), {28'd0, bus_if.ALU_OP}, {28'd0, vec_q[i].exp_op});
            check($sformatf("vec%0d_res", i), bus_if.ALU_RESULT, vec_q[i].exp_res);
            check($sformatf("vec%0d_zero", i), {31'd0, bus_if.ZERO}, {31'd0, vec_q[i].exp_zero});
        end

        write_reg(5'd9, 32'd43, 1'b1);
        drive_op(mk(OPC_BR, 3'b000, 1'b0, 5'd8, 5'd9, 2'd2, 1'b0, 32'd0, 32'd0, 4'd1, 32'd0));
        check("branch_ne_zero", {31'd0, bus_if.ZERO}, 32'd0);

        write_reg(5'd0, 32'hDEAD, 1'b1);
        bus_if.RS1 = 5'd0;
        #1;
        check("x0_stays_zero", bus_if.DATA1, 32'd0);
        write_reg(5'd7, 32'hCAFE, 1'b0);
        bus_if.RS1 = 5'd7;
        #1;
        check("x7_no_write", bus_if.DATA1, 32'd0);

        // Same-cycle read of the register being written.
        write_reg(5'd10, 32'h55, 1'b1);
        old_val = model_regs[10];
        @(negedge CLK);
        bus_if.RD = 5'd10; bus_if.WRITE_DATA = 32'hABCD; bus_if.REG_WRITE = 1'b1;
        bus_if.RS1 = 5'd10; bus_if.RS2 = 5'd10;
        #1;
`ifdef RF_WRITE_BYPASS_EN
        check("same_cycle_rd1", bus_if.DATA1, 32'hABCD);
        check("same_cycle_rd2", bus_if.DATA2, 32'hABCD);
`else
        check("same_cycle_rd1", bus_if.DATA1, old_val);
        check("same_cycle_rd2", bus_if.DATA2, old_val);
`endif
        @(posedge CLK);
        #1;
        bus_if.REG_WRITE = 1'b0;
        model_regs[10] = 32'hABCD;
        check("next_cycle_rd1", bus_if.DATA1, 32'hABCD);

        for (int n = 0; n < 300; n++) begin
            write_reg(5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 3) != 0));
            v.opcode  = opc_list[$urandom_range(0, 9)];
            v.funct3  = 3'($urandom_range(0, 7));
            v.bit30   = 1'($urandom_range(0, 1));
            v.rs1     = 5'($urandom_range(0, 31));
            v.rs2     = ($urandom_range(0, 4) == 0) ? v.rs1 : 5'($urandom_range(0, 31));
            v.a_sel   = 2'($urandom_range(0, 3));
            v.alu_src = 1'($urandom_range(0, 1));
            v.imm     = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 63)) : $urandom;
            v.pc      = $urandom;
            check_model(v, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
